// File: rtl/fft4_pkg.sv
// Shared types and constants for the streaming 4-point DFT engine.
package fft4_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int NPTS = 4;

  // Four-term sums of DATA_W samples need two extra bits to stay exact.
  function automatic int out_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/fft4_butterfly.sv
// Combinational radix-4 core: four complex samples in, four full-growth bins out.
module fft4_butterfly
  import fft4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OUT_W  = out_w(DATA_W)
) (
  input  logic signed [DATA_W-1:0] x_re_i [NPTS],
  input  logic signed [DATA_W-1:0] x_im_i [NPTS],
  input  logic                     inv_i,
  output logic signed [OUT_W-1:0]  y_re_o [NPTS],
  output logic signed [OUT_W-1:0]  y_im_o [NPTS]
);

  logic signed [OUT_W-1:0] a_re [NPTS];
  logic signed [OUT_W-1:0] a_im [NPTS];
  logic signed [OUT_W-1:0] p_re, p_im, q_re, q_im;
  logic signed [OUT_W-1:0] f1_re, f1_im, f3_re, f3_im;

  always_comb begin
    for (int i = 0; i < NPTS; i++) begin
      a_re[i] = {{(OUT_W-DATA_W){x_re_i[i][DATA_W-1]}}, x_re_i[i]};
      a_im[i] = {{(OUT_W-DATA_W){x_im_i[i][DATA_W-1]}}, x_im_i[i]};
    end
  end

  assign p_re = a_re[0] - a_re[2];
  assign p_im = a_im[0] - a_im[2];
  assign q_re = a_re[1] - a_re[3];
  assign q_im = a_im[1] - a_im[3];

  // Forward twiddle for bin 1 is -j; the inverse transform simply swaps bins 1 and 3.
  assign f1_re = p_re + q_im;
  assign f1_im = p_im - q_re;
  assign f3_re = p_re - q_im;
  assign f3_im = p_im + q_re;

  always_comb begin
    y_re_o[0] = a_re[0] + a_re[1] + a_re[2] + a_re[3];
    y_im_o[0] = a_im[0] + a_im[1] + a_im[2] + a_im[3];
    y_re_o[2] = a_re[0] - a_re[1] + a_re[2] - a_re[3];
    y_im_o[2] = a_im[0] - a_im[1] + a_im[2] - a_im[3];
    y_re_o[1] = inv_i ? f3_re : f1_re;
    y_im_o[1] = inv_i ? f3_im : f1_im;
    y_re_o[3] = inv_i ? f1_re : f3_re;
    y_im_o[3] = inv_i ? f1_im : f3_im;
  end

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point DFT: collect four samples, transform in one cycle,
// then emit the bins serially under valid/ready backpressure.
module fft4_stream
  import fft4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OUT_W  = out_w(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_inverse,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic [1:0]               out_idx,
  output logic                     out_last
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  k_q, k_d;
  logic        inv_q, inv_d;
  logic        load_en, calc_en;

  logic signed [DATA_W-1:0] x_re_q   [NPTS];
  logic signed [DATA_W-1:0] x_im_q   [NPTS];
  logic signed [OUT_W-1:0]  y_re     [NPTS];
  logic signed [OUT_W-1:0]  y_im     [NPTS];
  logic signed [OUT_W-1:0]  bin_re_q [NPTS];
  logic signed [OUT_W-1:0]  bin_im_q [NPTS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    inv_d   = inv_q;
    load_en = 1'b0;
    calc_en = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          load_en = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd0) inv_d = in_inverse;
          if (cnt_q == 2'd3) state_d = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        k_d     = 2'd0;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      k_q     <= 2'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      inv_q   <= inv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPTS; i++) begin
        x_re_q[i] <= '0;
        x_im_q[i] <= '0;
      end
    end else if (load_en) begin
      x_re_q[cnt_q] <= in_re;
      x_im_q[cnt_q] <= in_im;
    end
  end

  fft4_butterfly #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_butterfly (
    .x_re_i (x_re_q),
    .x_im_i (x_im_q),
    .inv_i  (inv_q),
    .y_re_o (y_re),
    .y_im_o (y_im)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NPTS; gi++) begin : g_bin
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bin_re_q[gi] <= '0;
          bin_im_q[gi] <= '0;
        end else if (calc_en) begin
          bin_re_q[gi] <= y_re[gi];
          bin_im_q[gi] <= y_im[gi];
        end
      end
    end
  endgenerate

  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  assign in_ready  = rst_n && (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_re    = out_valid ? bin_re_q[k_q] : '0;
  assign out_im    = out_valid ? bin_im_q[k_q] : '0;
  assign out_idx   = out_valid ? k_q : 2'd0;
  assign out_last  = out_valid && (k_q == 2'd3);

endmodule
